// File: rtl/cpu_trace_checker.sv
// Serial ASCII CPU-trace record parser: classifies register/memory write records and flags
// time, PC, address and register-index errors. Optional counters enabled by CHECKER_STATS_EN.
module cpu_trace_checker #(
  parameter int                  TIME_DIGITS = 4,
  parameter int                  TIME_W      = 16,
  parameter int                  GRF_DIGITS  = 4,
  parameter int                  PC_HEX      = 8,
  parameter logic [PC_HEX*4-1:0] PC_MIN      = 'h3000,
  parameter logic [PC_HEX*4-1:0] PC_MAX      = 'h6ffc,
  parameter logic [PC_HEX*4-1:0] ADDR_MAX    = 'h2ffc,
  parameter int                  GRF_NUM     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char,
  input  logic [15:0] freq,
  output logic [1:0]  format_type,
  output logic [3:0]  error_code,
  output logic [15:0] ok_count,
  output logic [15:0] err_count
);

  localparam int W      = PC_HEX * 4;
  localparam int GRF_W  = 32;
  localparam int TM_W   = (TIME_W > 16) ? TIME_W : 16;
  localparam int MAXD_A = (TIME_DIGITS > GRF_DIGITS) ? TIME_DIGITS : GRF_DIGITS;
  localparam int MAXD   = (MAXD_A > PC_HEX) ? MAXD_A : PC_HEX;
  localparam int CNT_W  = $clog2(MAXD + 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_TIME     = 4'd1;
  localparam logic [3:0] S_PC       = 4'd2;
  localparam logic [3:0] S_COLON_SP = 4'd3;
  localparam logic [3:0] S_GRF      = 4'd4;
  localparam logic [3:0] S_ADDR     = 4'd5;
  localparam logic [3:0] S_PRE_SP   = 4'd6;
  localparam logic [3:0] S_LT       = 4'd7;
  localparam logic [3:0] S_EQ_SP    = 4'd8;
  localparam logic [3:0] S_DATA     = 4'd9;

  localparam logic [7:0] CH_CARET  = 8'h5e;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3a;
  localparam logic [7:0] CH_SP     = 8'h20;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2a;
  localparam logic [7:0] CH_LT     = 8'h3c;
  localparam logic [7:0] CH_EQ     = 8'h3d;
  localparam logic [7:0] CH_HASH   = 8'h23;

  function automatic logic is_dec(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_hex(input logic [7:0] c);
    return is_dec(c) || ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] c);
    logic [7:0] v;
    v = is_dec(c) ? (c - 8'h30) : (c - 8'h57);
    return v[3:0];
  endfunction

  function automatic logic [TIME_W-1:0] time_acc(input logic [TIME_W-1:0] t,
                                                 input logic [3:0] d);
    return (t << 3) + (t << 1) + TIME_W'(d);
  endfunction

  // Register index saturates at all-ones instead of wrapping back into the legal range.
  function automatic logic [GRF_W-1:0] grf_acc(input logic [GRF_W-1:0] g,
                                               input logic [3:0] d);
    logic [GRF_W+3:0] wide;
    wide = ({4'd0, g} << 3) + ({4'd0, g} << 1) + {{GRF_W{1'b0}}, d};
    if (wide[GRF_W+3:GRF_W] != 4'd0) return '1;
    else return wide[GRF_W-1:0];
  endfunction

  logic [3:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [TIME_W-1:0] t_acc, t_nx;
  logic [W-1:0]     pc_acc, pc_nx;
  logic [W-1:0]     a_acc, a_nx;
  logic [GRF_W-1:0] g_acc, g_nx;
  logic             is_mem, mem_nx;
  logic             done, bad;
  logic [3:0]       nib;
  logic             dec_c, hex_c;

  assign nib   = hex_val(char);
  assign dec_c = is_dec(char);
  assign hex_c = is_hex(char);

  // Parse stage: one character per cycle
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    t_nx     = t_acc;
    pc_nx    = pc_acc;
    a_nx     = a_acc;
    g_nx     = g_acc;
    mem_nx   = is_mem;
    done     = 1'b0;
    bad      = 1'b0;
    case (state)
      // IDLE shares the abort path: it clears everything and only '^' leaves it
      S_IDLE: bad = 1'b1;
      S_TIME: begin
        if (dec_c && (cnt < CNT_W'(TIME_DIGITS))) begin
          t_nx   = time_acc(t_acc, nib);
          cnt_nx = cnt + CNT_W'(1);
        end else if ((char == CH_AT) && (cnt != '0)) begin
          state_nx = S_PC;
          cnt_nx   = '0;
        end else bad = 1'b1;
      end
      S_PC: begin
        if (hex_c && (cnt < CNT_W'(PC_HEX))) begin
          pc_nx  = {pc_acc[W-5:0], nib};
          cnt_nx = cnt + CNT_W'(1);
        end else if ((char == CH_COLON) && (cnt == CNT_W'(PC_HEX))) begin
          state_nx = S_COLON_SP;
          cnt_nx   = '0;
        end else bad = 1'b1;
      end
      S_COLON_SP: begin
        if (char == CH_DOLLAR) begin
          state_nx = S_GRF;
          mem_nx   = 1'b0;
        end else if (char == CH_STAR) begin
          state_nx = S_ADDR;
          mem_nx   = 1'b1;
        end else if (char != CH_SP) bad = 1'b1;
      end
      S_GRF: begin
        if (dec_c && (cnt < CNT_W'(GRF_DIGITS))) begin
          g_nx   = grf_acc(g_acc, nib);
          cnt_nx = cnt + CNT_W'(1);
        end else if ((char == CH_SP) && (cnt != '0)) state_nx = S_PRE_SP;
        else if ((char == CH_LT) && (cnt != '0)) state_nx = S_LT;
        else bad = 1'b1;
      end
      S_ADDR: begin
        if (hex_c && (cnt < CNT_W'(PC_HEX))) begin
          a_nx   = {a_acc[W-5:0], nib};
          cnt_nx = cnt + CNT_W'(1);
        end else if ((char == CH_SP) && (cnt == CNT_W'(PC_HEX))) state_nx = S_PRE_SP;
        else if ((char == CH_LT) && (cnt == CNT_W'(PC_HEX))) state_nx = S_LT;
        else bad = 1'b1;
      end
      S_PRE_SP: begin
        if (char == CH_LT) state_nx = S_LT;
        else if (char != CH_SP) bad = 1'b1;
      end
      S_LT: begin
        if (char == CH_EQ) state_nx = S_EQ_SP;
        else bad = 1'b1;
      end
      S_EQ_SP: begin
        if (hex_c) begin
          state_nx = S_DATA;
          cnt_nx   = CNT_W'(1);
        end else if (char != CH_SP) bad = 1'b1;
      end
      S_DATA: begin
        if (hex_c && (cnt < CNT_W'(PC_HEX))) cnt_nx = cnt + CNT_W'(1);
        else if ((char == CH_HASH) && (cnt == CNT_W'(PC_HEX))) begin
          done     = 1'b1;
          state_nx = S_IDLE;
        end else bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      state_nx = (char == CH_CARET) ? S_TIME : S_IDLE;
      cnt_nx   = '0;
      t_nx     = '0;
      pc_nx    = '0;
      a_nx     = '0;
      g_nx     = '0;
      mem_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      t_acc  <= '0;
      pc_acc <= '0;
      a_acc  <= '0;
      g_acc  <= '0;
      is_mem <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      t_acc  <= t_nx;
      pc_acc <= pc_nx;
      a_acc  <= a_nx;
      g_acc  <= g_nx;
      is_mem <= mem_nx;
    end
  end

  // Check stage: evaluated on the '#' cycle, visible for one cycle afterwards
  logic [TM_W-1:0] half, t_ext;
  logic [3:0]      err_nx;

  assign half  = TM_W'(freq >> 1);
  assign t_ext = TM_W'(t_acc);

  always_comb begin
    err_nx    = 4'd0;
    err_nx[0] = (half != '0) && ((t_ext & (half - TM_W'(1))) != '0);
    err_nx[1] = (pc_acc < PC_MIN) || (pc_acc > PC_MAX) || (pc_acc[1:0] != 2'b00);
    err_nx[2] = is_mem && ((a_acc > ADDR_MAX) || (a_acc[1:0] != 2'b00));
    err_nx[3] = !is_mem && (g_acc >= GRF_W'(GRF_NUM));
  end

  logic       vld_p1;
  logic       mem_p1;
  logic [3:0] err_p1;

  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= done;
  end

  always_ff @(posedge clk) begin
    mem_p1 <= is_mem;
    err_p1 <= err_nx;
  end

  assign format_type = vld_p1 ? (mem_p1 ? 2'd2 : 2'd1) : 2'd0;
  assign error_code  = vld_p1 ? err_p1 : 4'd0;

`ifdef CHECKER_STATS_EN
  logic [15:0] ok_q, err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ok_q  <= '0;
      err_q <= '0;
    end else if (vld_p1) begin
      if (err_p1 == 4'd0) ok_q  <= ok_q + 16'd1;
      else                err_q <= err_q + 16'd1;
    end
  end

  assign ok_count  = ok_q;
  assign err_count = err_q;
`else
  assign ok_count  = 16'd0;
  assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Randomised bench for cpu_trace_checker: builds a character stream of good and corrupted
// records, predicting each record's outcome from its field values.
module tb_cpu_trace_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  ch;
  logic [15:0] freq;
  logic [1:0]  format_type;
  logic [3:0]  error_code;
  logic [15:0] ok_count;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;
  int ok_exp = 0;
  int err_exp = 0;

  logic [7:0]  stream[$];
  logic [15:0] fq[$];
  logic [1:0]  et[$];
  logic [3:0]  ee[$];

  cpu_trace_checker dut (
    .clk         (clk),
    .reset       (reset),
    .char        (ch),
    .freq        (freq),
    .format_type (format_type),
    .error_code  (error_code),
    .ok_count    (ok_count),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic add_rec(input string s, input logic [15:0] f, input logic [1:0] typ,
                         input logic [3:0] err);
    for (int k = 0; k < s.len(); k++) begin
      stream.push_back(s[k]);
      fq.push_back(f);
      if (k == s.len() - 1) begin
        et.push_back(typ);
        ee.push_back(err);
      end else begin
        et.push_back(2'd0);
        ee.push_back(4'd0);
      end
    end
    if (typ != 2'd0) begin
      if (err == 4'd0) ok_exp++;
      else             err_exp++;
    end
  endtask

  task automatic add_gap();
    string junk;
    int n;
    junk = "x #Z";
    n = $urandom_range(0, 2);
    for (int k = 0; k < n; k++) begin
      stream.push_back(junk[$urandom_range(0, 3)]);
      fq.push_back(16'd4);
      et.push_back(2'd0);
      ee.push_back(4'd0);
    end
  endtask

  function automatic string sp();
    string r;
    int n;
    r = "";
    n = $urandom_range(0, 2);
    for (int k = 0; k < n; k++) r = {r, " "};
    return r;
  endfunction

  task automatic gen_random();
    int t, g, corrupt, half;
    logic [31:0] pc, a, d;
    logic [15:0] f;
    logic        mem;
    logic [3:0]  e;
    string ts, pcs, fld, lte, ds, s;
    f = 16'(1 << $urandom_range(0, 6));
    t = $urandom_range(0, 9999);
    case ($urandom_range(0, 3))
      0: pc = 32'h3000 + 32'($urandom_range(0, 32'h0fff)) * 4;
      1: pc = 32'($urandom_range(32'h2ff0, 32'h3010));
      2: pc = 32'($urandom_range(32'h6ff0, 32'h7010));
      default: pc = $urandom;
    endcase
    case ($urandom_range(0, 2))
      0: a = 32'($urandom_range(0, 32'h0bff)) * 4;
      1: a = 32'($urandom_range(32'h2ff0, 32'h3010));
      default: a = $urandom;
    endcase
    g   = $urandom_range(0, 40);
    mem = 1'($urandom_range(0, 1));
    d   = $urandom;
    corrupt = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : -1;
    if (corrupt == 4) mem = 1'b0;

    ts  = (corrupt == 0) ? $sformatf("%05d", t) : $sformatf("%0d", t);
    if (corrupt == 6) ts = "";
    pcs = $sformatf("%08h", pc);
    if (corrupt == 1) pcs.putc(3, 8'h41);
    if (corrupt == 5) pcs = {"0", pcs};
    if (mem) fld = {"*", $sformatf("%08h", a)};
    else if (corrupt == 4) fld = {"$", $sformatf("%05d", g)};
    else fld = {"$", $sformatf("%0d", g)};
    lte = (corrupt == 2) ? "< =" : "<=";
    ds  = (corrupt == 3) ? $sformatf("%07h", d[27:0]) : $sformatf("%08h", d);
    s = {"^", ts, "@", pcs, ":", sp(), fld, sp(), lte, sp(), ds, "#"};

    half = int'(f) / 2;
    e = 4'd0;
    e[0] = (half != 0) && ((t % half) != 0);
    e[1] = (pc < 32'h3000) || (pc > 32'h6ffc) || ((pc % 4) != 0);
    e[2] = mem && ((a > 32'h2ffc) || ((a % 4) != 0));
    e[3] = !mem && (g >= 32);
    if (corrupt >= 0) add_rec(s, f, 2'd0, 4'd0);
    else              add_rec(s, f, mem ? 2'd2 : 2'd1, e);
  endtask

  initial begin
    string rs;
    int    n;
    reset = 1'b1;
    ch    = 8'h20;
    freq  = 16'd4;

    add_rec("^10@00003000: $5 <= 0000000a#", 16'd4, 2'd1, 4'b0000);
    add_rec("^7@00003002: *00003000 <= 12345678#", 16'd4, 2'd2, 4'b0111);
    add_rec("^10@00003000: $32 <= 00000000#", 16'd4, 2'd1, 4'b1000);
    add_rec("^12345@00003000: $1 <= 00000000#", 16'd4, 2'd0, 4'b0000);
    add_rec("^1@0000^10@00003000: $1<=00000000#", 16'd2, 2'd1, 4'b0000);
    add_rec("^4@00006ffc:*00002ffc<=deadbeef#", 16'd8, 2'd2, 4'b0000);
    add_rec("^5@00007000:   $31   <=   00000000#", 16'd1, 2'd1, 4'b0010);
    add_rec("^3@00003000: $1 <= 0000000A#", 16'd4, 2'd0, 4'b0000);
    add_rec("^3@00003000: $1 <= 00000000#", 16'd4, 2'd1, 4'b0001);
    for (int r = 0; r < 150; r++) begin
      add_gap();
      gen_random();
    end
    for (int k = 0; k < 3; k++) begin
      stream.push_back(8'h20);
      fq.push_back(16'd4);
      et.push_back(2'd0);
      ee.push_back(4'd0);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_type", 32'(format_type), 32'd0);
    chk("reset_err", 32'(error_code), 32'd0);
    chk("reset_ok", 32'(ok_count), 32'd0);
    chk("reset_errcnt", 32'(err_count), 32'd0);
    reset = 1'b0;

    n = stream.size();
    for (int i = 0; i < n; i++) begin
      ch   = stream[i];
      freq = fq[i];
      @(negedge clk);
      chk($sformatf("type@%0d", i), 32'(format_type), 32'(et[i]));
      chk($sformatf("err@%0d", i), 32'(error_code), 32'(ee[i]));
    end
    @(negedge clk);
`ifdef CHECKER_STATS_EN
    chk("ok_count", 32'(ok_count), 32'(ok_exp));
    chk("err_count", 32'(err_count), 32'(err_exp));
`else
    chk("ok_count", 32'(ok_count), 32'd0);
    chk("err_count", 32'(err_count), 32'd0);
`endif

    // Reset pulse on a data digit aborts the record and clears the counters.
    rs = "^10@00003000: $5 <= 0000000a#";
    for (int k = 0; k < rs.len(); k++) begin
      ch    = rs[k];
      reset = (k == 24);
      @(negedge clk);
      chk($sformatf("midreset_type@%0d", k), 32'(format_type), 32'd0);
      chk($sformatf("midreset_err@%0d", k), 32'(error_code), 32'd0);
    end
    reset = 1'b0;
    ch    = 8'h20;
    @(negedge clk);
    chk("midreset_type_after", 32'(format_type), 32'd0);
    chk("midreset_ok", 32'(ok_count), 32'd0);
    chk("midreset_errcnt", 32'(err_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
